// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// IF stage looks up combinationally; EX stage resolves, redirects and trains the table.
module branch_predictor #(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [31:0]      if_pc,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             ex_valid,
   input  logic             ex_is_jump,
   input  logic [31:0]      ex_pc,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   input  logic             ex_pred_taken,
   input  logic [31:0]      ex_pred_target,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispred
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];
   logic [ENTRIES-1:0] jmp_q, jmp_d;
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];
   logic [CNT_W-1:0]   br_q, br_d, mp_q, mp_d;

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;
   logic [1:0]       ex_ctr;

   // Only the index and tag fields of the fetch PC matter for lookup.
   logic [31:0] unused_if_pc;
   assign unused_if_pc = if_pc;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign ex_ctr = ctr_q[ex_idx];

   always_comb begin
      pred_taken  = if_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);
      pred_target = pred_taken ? target_q[if_idx] : 32'd0;
      mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_pred_target != ex_target)));
      redirect_pc = (ex_valid && ex_taken) ? ex_target : ex_pc + 32'd4;
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      jmp_d    = jmp_q;
      ctr_d    = ctr_q;
      if (clear) begin
         valid_d = '0;
      end else if (ex_valid) begin
         if (ex_taken) begin
            target_d[ex_idx] = ex_target;
            jmp_d[ex_idx]    = ex_is_jump;
            if (ex_hit) begin
               ctr_d[ex_idx] = (ex_is_jump || ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
            end else begin
               valid_d[ex_idx] = 1'b1;
               tag_d[ex_idx]   = ex_tag;
               ctr_d[ex_idx]   = ex_is_jump ? 2'b11 : 2'b10;
            end
         end else if (ex_hit) begin
            ctr_d[ex_idx] = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
         end
      end
   end

   // Statistics keep counting through clear and stick at all-ones.
   always_comb begin
      br_d = br_q;
      mp_d = mp_q;
      if (ex_valid && (br_q != '1)) br_d = br_q + CNT_W'(1);
      if (mispredict && (mp_q != '1)) mp_d = mp_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         jmp_q   <= '0;
         br_q    <= '0;
         mp_q    <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         jmp_q    <= jmp_d;
         ctr_q    <= ctr_d;
         br_q     <= br_d;
         mp_q     <= mp_d;
      end
   end

   assign stat_branches = br_q;
   assign stat_mispred  = mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: vector table for train/lookup behaviour,
// then hand-written sequences for reset, clear and counter saturation.
module tb_branch_predictor;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset, clear;
   logic [31:0]      if_pc;
   logic             pred_taken;
   logic [31:0]      pred_target;
   logic             ex_valid, ex_is_jump, ex_taken, ex_pred_taken;
   logic [31:0]      ex_pc, ex_target, ex_pred_target;
   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] stat_branches, stat_mispred;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .clear         (clear),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .ex_valid      (ex_valid),
      .ex_is_jump    (ex_is_jump),
      .ex_pc         (ex_pc),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_pred_taken (ex_pred_taken),
      .ex_pred_target(ex_pred_target),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc),
      .stat_branches (stat_branches),
      .stat_mispred  (stat_mispred)
   );

   typedef struct {
      logic        jmp;
      logic [31:0] pc;
      logic        tk;
      logic [31:0] tgt;
      logic        ptk;
      logic [31:0] ptgt;
      logic [31:0] lpc;
      logic        emp;
      logic [31:0] eredir;
      logic        eptk;
      logic [31:0] eptgt;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic jmp, logic [31:0] pc, logic tk, logic [31:0] tgt,
                               logic ptk, logic [31:0] ptgt, logic [31:0] lpc, logic emp,
                               logic [31:0] eredir, logic eptk, logic [31:0] eptgt);
      vec_t v;
      v.jmp = jmp; v.pc = pc; v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
      v.lpc = lpc; v.emp = emp; v.eredir = eredir; v.eptk = eptk; v.eptgt = eptgt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_ex(input logic jmp, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      ex_valid = 1'b1; ex_is_jump = jmp; ex_pc = pc; ex_taken = tk;
      ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
   endtask

   int exp_br;
   int exp_mp;

   initial begin
      reset = 1'b0; clear = 1'b0; if_pc = 32'h0040_0010;
      ex_pc = 32'd0; ex_target = 32'd0; ex_pred_target = 32'd0;
      idle_ex();
      #2;
      chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("reset_pred_target", pred_target, 32'd0);
      chk("reset_stat_br", {28'd0, stat_branches}, 32'd0);
      chk("reset_stat_mp", {28'd0, stat_mispred}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      //          jmp pc            tk  tgt           ptk ptgt          lookup        mp  redirect     ptk tgt
      vecs[0]  = mk(0, 32'h0040_0010, 1, 32'h0040_0040, 0, 32'h0,         32'h0040_0010, 1, 32'h0040_0040, 1, 32'h0040_0040);
      vecs[1]  = mk(0, 32'h0040_0010, 0, 32'h0,         1, 32'h0040_0040, 32'h0040_0010, 1, 32'h0040_0014, 0, 32'h0);
      vecs[2]  = mk(0, 32'h0040_0010, 0, 32'h0,         0, 32'h0,         32'h0040_0010, 0, 32'h0040_0014, 0, 32'h0);
      vecs[3]  = mk(0, 32'h0040_0010, 1, 32'h0040_0040, 0, 32'h0,         32'h0040_0010, 1, 32'h0040_0040, 0, 32'h0);
      vecs[4]  = mk(0, 32'h0040_0010, 1, 32'h0040_0040, 0, 32'h0,         32'h0040_0010, 1, 32'h0040_0040, 1, 32'h0040_0040);
      vecs[5]  = mk(0, 32'h0040_0010, 1, 32'h0040_0040, 1, 32'h0040_0040, 32'h0040_0010, 0, 32'h0040_0040, 1, 32'h0040_0040);
      vecs[6]  = mk(0, 32'h0040_0010, 1, 32'h0040_0040, 1, 32'h0040_0040, 32'h0040_0010, 0, 32'h0040_0040, 1, 32'h0040_0040);
      vecs[7]  = mk(0, 32'h0040_0010, 0, 32'h0,         1, 32'h0040_0040, 32'h0040_0010, 1, 32'h0040_0014, 1, 32'h0040_0040);
      vecs[8]  = mk(0, 32'h0040_0050, 0, 32'h0,         0, 32'h0,         32'h0040_0050, 0, 32'h0040_0054, 0, 32'h0);
      vecs[9]  = mk(0, 32'h0040_0050, 1, 32'h0040_0200, 0, 32'h0,         32'h0040_0050, 1, 32'h0040_0200, 1, 32'h0040_0200);
      vecs[10] = mk(0, 32'h0040_0090, 0, 32'h0,         0, 32'h0,         32'h0040_0010, 0, 32'h0040_0094, 0, 32'h0);
      vecs[11] = mk(1, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'h0,         32'h0040_0020, 1, 32'h0040_0100, 1, 32'h0040_0100);
      vecs[12] = mk(1, 32'h0040_0020, 0, 32'h0,         1, 32'h0040_0100, 32'h0040_0020, 1, 32'h0040_0024, 1, 32'h0040_0100);
      vecs[13] = mk(1, 32'h0040_0020, 0, 32'h0,         1, 32'h0040_0100, 32'h0040_0020, 1, 32'h0040_0024, 1, 32'h0040_0100);
      vecs[14] = mk(0, 32'h0040_0050, 1, 32'h0040_0300, 1, 32'h0040_0200, 32'h0040_0050, 1, 32'h0040_0300, 1, 32'h0040_0300);
      vecs[15] = mk(0, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 32'h0);

      exp_br = 0;
      exp_mp = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive_ex(vecs[i].jmp, vecs[i].pc, vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
         #1;
         chk($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].emp});
         chk($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].eredir);
         if (exp_br < 15) exp_br++;
         if (vecs[i].emp && exp_mp < 15) exp_mp++;
         @(posedge clk);
         #1;
         idle_ex();
         if_pc = vecs[i].lpc;
         #1;
         chk($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].eptk});
         chk($sformatf("v%0d_pred_target", i), pred_target, vecs[i].eptgt);
         chk($sformatf("v%0d_stat_br", i), {28'd0, stat_branches}, exp_br);
         chk($sformatf("v%0d_stat_mp", i), {28'd0, stat_mispred}, exp_mp);
      end

      // Idle resolve: no mispredict, fall-through redirect.
      @(negedge clk);
      ex_pc = 32'h0040_0070; ex_taken = 1'b1; ex_target = 32'h0040_0900;
      #1;
      chk("idle_mispredict", {31'd0, mispredict}, 32'd0);
      chk("idle_redirect", redirect_pc, 32'h0040_0074);
      idle_ex();

      // Asynchronous reset between edges; resolve path stays combinational.
      @(negedge clk);
      if_pc = 32'h0040_0050;
      drive_ex(0, 32'h0040_0010, 1, 32'h0040_0040, 0, 32'h0);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("midrst_pred_target", pred_target, 32'd0);
      chk("midrst_stat_br", {28'd0, stat_branches}, 32'd0);
      chk("midrst_stat_mp", {28'd0, stat_mispred}, 32'd0);
      chk("midrst_mispredict", {31'd0, mispredict}, 32'd1);
      chk("midrst_redirect", redirect_pc, 32'h0040_0040);
      @(negedge clk);
      reset = 1'b1;

      // First edge after release trains normally.
      @(posedge clk);
      #1;
      idle_ex();
      if_pc = 32'h0040_0010;
      #1;
      chk("post_rst_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("post_rst_pred_target", pred_target, 32'h0040_0040);
      chk("post_rst_stat_br", {28'd0, stat_branches}, 32'd1);

      // Clear wins over a same-cycle training write; stats still count.
      @(negedge clk);
      clear = 1'b1;
      drive_ex(1, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'h0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      idle_ex();
      if_pc = 32'h0040_0010;
      #1;
      chk("clear_old_entry", {31'd0, pred_taken}, 32'd0);
      if_pc = 32'h0040_0020;
      #1;
      chk("clear_dropped_write", {31'd0, pred_taken}, 32'd0);
      chk("clear_stat_br", {28'd0, stat_branches}, 32'd2);
      chk("clear_stat_mp", {28'd0, stat_mispred}, 32'd2);

      // 20 correctly predicted not-taken resolves: branch count sticks at 15.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive_ex(0, 32'h0040_0100, 0, 32'h0, 0, 32'h0);
      end
      @(negedge clk);
      idle_ex();
      #1;
      chk("sat_stat_br", {28'd0, stat_branches}, 32'd15);
      chk("sat_stat_mp", {28'd0, stat_mispred}, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
